freq_meter: RTL and testbench

//   Gated-window frequency meter: counts rising edges of an asynchronous input

---
 rtl/freq_meter_if.sv | 15 +
 rtl/freq_meter.sv | 98 +++++++++
 tb/tb_freq_meter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
// Signal bundle for freq_meter: measurement controls in, published window result out.
interface freq_meter_if #(
    parameter int W = 8
);
    logic         en;
    logic         sig_in;
    logic [W-1:0] data;
    logic         ovf;
    logic         valid;

    // valid is a one-cycle strobe with no ready/backpressure: data and ovf change
    // only in the cycle valid is high and are stable between strobes.
    modport master (output en, output sig_in, input data, input ovf, input valid);
    modport slave  (input en, input sig_in, output data, output ovf, output valid);
endinterface

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts synchronized rising edges of bus.sig_in over
// GATE_CYCLES clocks and publishes the count. Define SATURATE_EN to clamp instead of wrap.
`ifndef F_1Hz
`define F_1Hz 50_000_000
`endif

module freq_meter #(
    parameter int GATE_CYCLES = `F_1Hz,
    parameter int W           = 8
) (
    input logic         clk,
    input logic         rst_n,
    freq_meter_if.slave bus
);
    localparam int             GW   = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]  LAST = GW'(GATE_CYCLES - 1);
    localparam logic [W-1:0]   MAX  = '1;

    logic          r_s1, r_s2, r_s3;
    logic [GW-1:0] r_gcnt;
    logic [W-1:0]  r_acc;
    logic          r_sticky;
    logic [W-1:0]  r_data;
    logic          r_ovf;
    logic          r_valid;

    logic          w_edge;
    logic          w_full;
    logic          w_terminal;
    logic [W-1:0]  w_acc_next;
    logic          w_ovf_next;

    // Two flops resolve metastability; the third gives the previous level for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge     = r_s2 & ~r_s3;
    assign w_full     = (r_acc == MAX);
    assign w_terminal = (r_gcnt == LAST);
    assign w_ovf_next = r_sticky | (w_edge & w_full);

    always_comb begin
        w_acc_next = r_acc;
        if (w_edge) begin
            if (w_full) begin
`ifdef SATURATE_EN
                w_acc_next = MAX;
`else
                w_acc_next = '0;
`endif
            end else begin
                w_acc_next = r_acc + W'(1);
            end
        end
    end

    // The terminal cycle folds in its own edge and restarts the window with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcnt   <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else if (!bus.en) begin
            r_gcnt   <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_valid  <= 1'b0;
        end else if (w_terminal) begin
            r_data   <= w_acc_next;
            r_ovf    <= w_ovf_next;
            r_valid  <= 1'b1;
            r_gcnt   <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_gcnt   <= r_gcnt + GW'(1);
            r_acc    <= w_acc_next;
            r_sticky <= w_ovf_next;
            r_valid  <= 1'b0;
        end
    end

    assign bus.data  = r_data;
    assign bus.ovf   = r_ovf;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (20- and 40-cycle windows, W=4) share the stimulus.
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int W     = 4;
  localparam int G20   = 20;
  localparam int G40   = 40;
  localparam int NHIST = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sig   = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit lvl [NHIST];

  freq_meter_if #(.W(W)) bus20 ();
  freq_meter_if #(.W(W)) bus40 ();

  assign bus20.en     = en;
  assign bus20.sig_in = sig;
  assign bus40.en     = en;
  assign bus40.sig_in = sig;

  freq_meter #(.GATE_CYCLES(G20), .W(W)) dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20.slave));
  freq_meter #(.GATE_CYCLES(G40), .W(W)) dut40 (.clk(clk), .rst_n(rst_n), .bus(bus40.slave));

  always #5 clk = ~clk;

  // Level of sig_in as seen at each rising edge; held-in-reset edges read as 0.
  always @(posedge clk) begin
    if (cyc < NHIST) lvl[cyc] <= rst_n ? sig : 1'b0;
    cyc <= cyc + 1;
  end

  // Reference: a rise first seen at edge k is counted at edge k+2; count those in the window.
  function automatic int edges_in(input int t_end, input int g);
    int cnt;
    cnt = 0;
    for (int n = t_end - g + 1; n <= t_end; n++) begin
      if (n >= 2 && n - 2 < NHIST) begin
        if (lvl[n-2] && (n < 3 || !lvl[n-3])) cnt++;
      end
    end
    return cnt;
  endfunction

  function automatic logic [W-1:0] exp_data(input int cnt);
    int lim;
    lim = (1 << W) - 1;
`ifdef SATURATE_EN
    return (cnt > lim) ? W'(lim) : W'(cnt);
`else
    return W'(cnt % (1 << W));
`endif
  endfunction

  function automatic logic exp_ovf(input int cnt);
    return (cnt > (1 << W) - 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic pat(input int c, input int period);
    return ((c % period) < (period / 2)) ? 1'b1 : 1'b0;
  endfunction

  // Waits (bounded) for a valid strobe, optionally driving a periodic sig_in meanwhile.
  task automatic wait_valid(input bit use40, input int limit, input int period,
                            output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if ((use40 ? bus40.valid : bus20.valid) === 1'b1) begin
        ok = 1'b1;
        t  = cyc - 1;
      end
      if (period > 0) sig = pat(cyc, period);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sig = ~sig;
    end
    #1;
    total++; if (bus20.data !== 4'd0) begin bad++; $display("FAIL reset_data20 got=%0d want=0", bus20.data); end
    total++; if (bus20.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf20 got=%0b want=0", bus20.ovf); end
    total++; if (bus20.valid !== 1'b0) begin bad++; $display("FAIL reset_valid20 got=%0b want=0", bus20.valid); end
    total++; if (bus40.data !== 4'd0) begin bad++; $display("FAIL reset_data40 got=%0d want=0", bus40.data); end
    total++; if (bus40.valid !== 1'b0) begin bad++; $display("FAIL reset_valid40 got=%0b want=0", bus40.valid); end
    @(negedge clk);
    sig   = 1'b0;
    en    = 1'b1;
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) begin
        total++; if (bus20.valid !== 1'b0) begin bad++; $display("FAIL release_early_valid cyc=%0d got=%0b want=0", i, bus20.valid); end
      end else begin
        total++; if (bus20.valid !== 1'b1) begin bad++; $display("FAIL release_first_valid got=%0b want=1", bus20.valid); end
        total++; if (bus20.data !== 4'd0) begin bad++; $display("FAIL release_first_data got=%0d want=0", bus20.data); end
      end
    end
  endtask

  task automatic test_steady();
    int t, last, nval, c;
    last = -1;
    nval = 0;
    sig  = pat(cyc, 4);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (bus20.valid === 1'b1) begin
        t = cyc - 1;
        c = edges_in(t, G20);
        nval++;
        total++; if (bus20.data !== exp_data(c)) begin bad++; $display("FAIL steady_data got=%0d want=%0d", bus20.data, exp_data(c)); end
        total++; if (bus20.ovf !== 1'b0) begin bad++; $display("FAIL steady_ovf got=%0b want=0", bus20.ovf); end
        if (last >= 0) begin
          total++; if (t - last != G20) begin bad++; $display("FAIL steady_interval got=%0d want=%0d", t - last, G20); end
        end
        last = t;
      end
      sig = pat(cyc, 4);
    end
    total++; if (nval != 6) begin bad++; $display("FAIL steady_valid_count got=%0d want=6", nval); end
    total++; if (bus20.data !== 4'd5) begin bad++; $display("FAIL steady_data_5 got=%0d want=5", bus20.data); end
  endtask

  task automatic test_random();
    int t, c, hold, last20, last40, n20, n40;
    hold = 1; last20 = -1; last40 = -1; n20 = 0; n40 = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      t = cyc - 1;
      if (bus20.valid === 1'b1) begin
        c = edges_in(t, G20);
        n20++;
        total++; if (bus20.data !== exp_data(c)) begin bad++; $display("FAIL rand_data20 t=%0d got=%0d want=%0d", t, bus20.data, exp_data(c)); end
        total++; if (bus20.ovf !== exp_ovf(c)) begin bad++; $display("FAIL rand_ovf20 t=%0d got=%0b want=%0b", t, bus20.ovf, exp_ovf(c)); end
        if (last20 >= 0) begin
          total++; if (t - last20 != G20) begin bad++; $display("FAIL rand_interval20 got=%0d want=%0d", t - last20, G20); end
        end
        last20 = t;
      end
      if (bus40.valid === 1'b1) begin
        c = edges_in(t, G40);
        n40++;
        total++; if (bus40.data !== exp_data(c)) begin bad++; $display("FAIL rand_data40 t=%0d got=%0d want=%0d", t, bus40.data, exp_data(c)); end
        total++; if (bus40.ovf !== exp_ovf(c)) begin bad++; $display("FAIL rand_ovf40 t=%0d got=%0b want=%0b", t, bus40.ovf, exp_ovf(c)); end
        if (last40 >= 0) begin
          total++; if (t - last40 != G40) begin bad++; $display("FAIL rand_interval40 got=%0d want=%0d", t - last40, G40); end
        end
        last40 = t;
      end
      hold--;
      if (hold == 0) begin
        sig  = ~sig;
        hold = $urandom_range(1, 3);
      end
    end
    total++; if (n20 < 19) begin bad++; $display("FAIL rand_count20 got=%0d want>=19", n20); end
    total++; if (n40 < 9) begin bad++; $display("FAIL rand_count40 got=%0d want>=9", n40); end
  endtask

  task automatic test_overflow();
    int t, c, nwin, last;
    logic [W-1:0] want;
`ifdef SATURATE_EN
    want = 4'd15;
`else
    want = 4'd4;
`endif
    nwin = 0;
    last = -1;
    sig  = pat(cyc, 2);
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (bus40.valid === 1'b1) begin
        t = cyc - 1;
        c = edges_in(t, G40);
        total++; if (bus40.data !== exp_data(c)) begin bad++; $display("FAIL ovf_model_data got=%0d want=%0d", bus40.data, exp_data(c)); end
        total++; if (bus40.ovf !== exp_ovf(c)) begin bad++; $display("FAIL ovf_model_flag got=%0b want=%0b", bus40.ovf, exp_ovf(c)); end
        if (nwin >= 1) begin
          total++; if (bus40.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", bus40.ovf); end
          total++; if (bus40.data !== want) begin bad++; $display("FAIL ovf_data got=%0d want=%0d", bus40.data, want); end
        end
        if (last >= 0) begin
          total++; if (t - last != G40) begin bad++; $display("FAIL ovf_interval got=%0d want=%0d", t - last, G40); end
        end
        last = t;
        nwin++;
      end
      sig = pat(cyc, 2);
    end
    total++; if (nwin < 3) begin bad++; $display("FAIL ovf_window_count got=%0d want>=3", nwin); end
  endtask

  task automatic test_boundary();
    int t0, t;
    bit ok;
    sig = 1'b0;
    wait_valid(1'b0, 30, 0, t0, ok);
    wait_valid(1'b0, 30, 0, t0, ok);
    total++; if (!ok) begin bad++; $display("FAIL bnd_align_timeout got=0 want=1"); end
    while (cyc < t0 + 18) @(negedge clk);
    sig = 1'b1;
    wait_valid(1'b0, 25, 0, t, ok);
    total++; if (!ok || t != t0 + 20) begin bad++; $display("FAIL bnd_valid_time got=%0d want=%0d", t, t0 + 20); end
    total++; if (bus20.data !== 4'd1) begin bad++; $display("FAIL bnd_terminal_edge got=%0d want=1", bus20.data); end
    wait_valid(1'b0, 25, 0, t, ok);
    total++; if (!ok || t != t0 + 40) begin bad++; $display("FAIL bnd_next_time got=%0d want=%0d", t, t0 + 40); end
    total++; if (bus20.data !== 4'd0) begin bad++; $display("FAIL bnd_next_data got=%0d want=0", bus20.data); end
    sig = 1'b0;
  endtask

  task automatic test_enable();
    int t, t2, s;
    bit ok;
    wait_valid(1'b0, 30, 4, t, ok);
    wait_valid(1'b0, 30, 4, t, ok);
    total++; if (!ok || bus20.data !== 4'd5) begin bad++; $display("FAIL en_pre_data got=%0d want=5", bus20.data); end
    while (cyc < t + 11) begin
      @(negedge clk);
      sig = pat(cyc, 4);
    end
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++; if (bus20.valid !== 1'b0) begin bad++; $display("FAIL en_off_valid i=%0d got=%0b want=0", i, bus20.valid); end
      total++; if (bus20.data !== 4'd5) begin bad++; $display("FAIL en_off_hold i=%0d got=%0d want=5", i, bus20.data); end
      sig = pat(cyc, 4);
    end
    en = 1'b1;
    s  = cyc;
    wait_valid(1'b0, 25, 4, t2, ok);
    total++; if (!ok || t2 != s + 19) begin bad++; $display("FAIL en_first_valid got=%0d want=%0d", t2, s + 19); end
    total++; if (bus20.data !== exp_data(edges_in(t2, G20))) begin bad++; $display("FAIL en_first_data got=%0d want=%0d", bus20.data, exp_data(edges_in(t2, G20))); end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    wait_valid(1'b0, 30, 4, t, ok);
    total++; if (!ok || bus20.data !== 4'd5) begin bad++; $display("FAIL mid_pre_data got=%0d want=5", bus20.data); end
    while (cyc < t + 13) begin
      @(negedge clk);
      sig = pat(cyc, 4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus20.data !== 4'd0) begin bad++; $display("FAIL mid_rst_data got=%0d want=0", bus20.data); end
    total++; if (bus20.ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%0b want=0", bus20.ovf); end
    total++; if (bus40.data !== 4'd0) begin bad++; $display("FAIL mid_rst_data40 got=%0d want=0", bus40.data); end
    @(negedge clk);
    sig = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i < 20) begin
        total++; if (bus20.valid !== 1'b0) begin bad++; $display("FAIL mid_early_valid i=%0d got=%0b want=0", i, bus20.valid); end
      end else begin
        total++; if (bus20.valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid got=%0b want=1", bus20.valid); end
        total++; if (bus20.data !== 4'd0) begin bad++; $display("FAIL mid_first_data got=%0d want=0", bus20.data); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_random();
    test_overflow();
    test_boundary();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
